// File: rtl/mips_defs.sv
// ============================================================================
//  Package     : mips_defs
//  Description : Shared definitions for the multiply/divide unit of the
//                pipelined MIPS core: md_op opcode encodings, controller
//                state encoding, default latencies and an opcode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

   // md_op encodings (6 and 7 are reserved and ignored by the controller)
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   // Default busy-window lengths
   localparam int DEF_MUL_CYCLES = 5;
   localparam int DEF_DIV_CYCLES = 10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   // True for the four opcodes that open a multi-cycle busy window
   function automatic logic is_arith(input logic [2:0] op);
      return (op <= MD_DIVU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
//  Module      : md_arith
//  Description : Purely combinational 32x32 multiply / divide datapath.
//                Produces {hi,lo} for mult/multu (64-bit product) and
//                div/divu (remainder,quotient), plus a divide-by-zero flag.
//  Ports       : i_op           - md_op code (MD_MULT..MD_DIVU used)
//                i_a            - rs operand (multiplicand / dividend)
//                i_b            - rt operand (multiplier / divisor)
//                o_result[63:0] - {hi,lo}; zero for non-arithmetic codes
//                o_div_by_zero  - i_b is zero
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_arith
   import mips_defs::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result,
   output logic        o_div_by_zero
);

   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic               w_ovf;
   logic signed [31:0] w_sa;
   logic signed [31:0] w_sb;
   logic signed [31:0] w_sq;
   logic signed [31:0] w_sr;
   logic        [31:0] w_ub;
   logic        [31:0] w_uq;
   logic        [31:0] w_ur;

   assign o_div_by_zero = (i_b == 32'd0);

   // Sign-extend to 64 bits so the low 64 bits of the product are exact
   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Most-negative / -1 is replaced by a divide by +1, which yields the
   // architected quotient 0x80000000 and remainder 0 without relying on
   // simulator overflow behaviour. A zero divisor is replaced by 1 to keep
   // the datapath free of X; the controller discards that result anyway.
   assign w_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
   assign w_sa  = i_a;
   assign w_sb  = (o_div_by_zero || w_ovf) ? 32'sd1 : i_b;
   assign w_sq  = w_sa / w_sb;   // truncates toward zero
   assign w_sr  = w_sa % w_sb;   // sign follows the dividend

   assign w_ub  = o_div_by_zero ? 32'd1 : i_b;
   assign w_uq  = i_a / w_ub;
   assign w_ur  = i_a % w_ub;

   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_prod_s;
         MD_MULTU: o_result = w_prod_u;
         MD_DIV:   o_result = {w_sr, w_sq};
         MD_DIVU:  o_result = {w_ur, w_uq};
         default:  o_result = 64'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// ============================================================================
//  Module      : md_ctrl
//  Description : Multi-cycle multiply/divide controller for the E stage.
//                Latches the arithmetic result at start, holds busy for a
//                fixed latency, then commits it to HI/LO. mthi/mtlo write
//                HI/LO in a single cycle. Raises stall while a HI/LO-class
//                instruction in D would collide with an active operation.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous active-high reset
//                start    - E-stage md-class instruction valid
//                md_op    - 0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo
//                rs_val   - forwarded rs operand
//                rt_val   - forwarded rt operand
//                d_is_md  - D-stage instruction touches HI/LO
//                busy     - operation in progress
//                stall    - freeze PC/F/D and bubble E
//                hi, lo   - committed HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_ctrl
   import mips_defs::*;
#(
   parameter int MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES,
   parameter int CNT_W      = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_pend_hi;
   logic [31:0]        r_pend_lo;
   logic               r_pend_skip;

   logic               w_arith;
   logic               w_is_div;
   logic [63:0]        w_result;
   logic               w_div_by_zero;

   md_arith u_arith (
      .i_op          (md_op),
      .i_a           (rs_val),
      .i_b           (rt_val),
      .o_result      (w_result),
      .o_div_by_zero (w_div_by_zero)
   );

   assign w_arith  = is_arith(md_op);
   assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_hi        <= 32'd0;
         r_lo        <= 32'd0;
         r_pend_hi   <= 32'd0;
         r_pend_lo   <= 32'd0;
         r_pend_skip <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (w_arith) begin
                     r_pend_hi   <= w_result[63:32];
                     r_pend_lo   <= w_result[31:0];
                     // Divide by zero keeps the full latency but never commits
                     r_pend_skip <= w_is_div && w_div_by_zero;
                     r_cnt       <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                     r_busy      <= 1'b1;
                     r_state     <= RUN;
                  end else if (md_op == MD_MTHI) begin
                     r_hi <= rs_val;
                  end else if (md_op == MD_MTLO) begin
                     r_lo <= rs_val;
                  end
               end
            end
            RUN: begin
               // start is ignored here; the hazard logic never issues one
               if (r_cnt == CNT_W'(1)) begin
                  if (!r_pend_skip) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign hi    = r_hi;
   assign lo    = r_lo;
   assign stall = d_is_md && (r_busy || (start && w_arith));

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Scoreboard testbench for md_ctrl. Stimulus pushes the
//                expected busy/stall/hi/lo for every driven cycle; a monitor
//                pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      string       name;
      logic        busy;
      logic        stall;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        expq[$];
   int          checks;
   int          errors;
   logic [31:0] cur_hi;
   logic [31:0] cur_lo;

   md_ctrl #(
      .MUL_CYCLES (5),
      .DIV_CYCLES (10),
      .CNT_W      (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input string nm, input logic b, input logic s,
                               input logic [31:0] h, input logic [31:0] l);
      exp_t e;
      e.name  = nm;
      e.busy  = b;
      e.stall = s;
      e.hi    = h;
      e.lo    = l;
      return e;
   endfunction

   // One cycle: drive inputs just after the rising edge, queue the expectation
   task automatic cyc(input logic s, input logic [2:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic dmd, input logic rst,
                      input exp_t e);
      @(posedge clk);
      #1;
      start   = s;
      md_op   = op;
      rs_val  = rs;
      rt_val  = rt;
      d_is_md = dmd;
      reset   = rst;
      expq.push_back(e);
   endtask

   // Start cycle, n busy cycles with old HI/LO visible, then the committed result
   task automatic run_arith(input string nm, input logic [2:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, input logic dmd, input int n,
                            input logic [31:0] nhi, input logic [31:0] nlo);
      cyc(1'b1, op, rs, rt, dmd, 1'b0, mk({nm, "_start"}, 1'b0, dmd, cur_hi, cur_lo));
      for (int i = 0; i < n; i++)
         cyc(1'b0, op, $urandom, $urandom, dmd, 1'b0,
             mk({nm, "_busy"}, 1'b1, dmd, cur_hi, cur_lo));
      cur_hi = nhi;
      cur_lo = nlo;
      cyc(1'b0, 3'd0, 32'd0, 32'd0, dmd, 1'b0, mk({nm, "_done"}, 1'b0, 1'b0, cur_hi, cur_lo));
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (start && busy && !reset) begin
         errors++;
         $display("FAIL start_while_busy: start=%0b busy=%0b required no overlap", start, busy);
      end
      if (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (busy !== e.busy) begin
            errors++;
            $display("FAIL %s busy: got %0b expected %0b", e.name, busy, e.busy);
         end
         checks++;
         if (stall !== e.stall) begin
            errors++;
            $display("FAIL %s stall: got %0b expected %0b", e.name, stall, e.stall);
         end
         checks++;
         if (hi !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %08h expected %08h", e.name, hi, e.hi);
         end
         checks++;
         if (lo !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %08h expected %08h", e.name, lo, e.lo);
         end
      end
   end

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      start   = 1'b0;
      md_op   = 3'd0;
      rs_val  = 32'd0;
      rt_val  = 32'd0;
      d_is_md = 1'b0;
      cur_hi  = 32'd0;
      cur_lo  = 32'd0;

      // Reset state
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, mk("reset0", 1'b0, 1'b0, 32'd0, 32'd0));
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, mk("reset1", 1'b0, 1'b0, 32'd0, 32'd0));

      // mult -2 * 3 = -6
      run_arith("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      // multu 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001, with D-stage hazard
      run_arith("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      // div -7 / 2 = -3 rem -1, with D-stage hazard
      run_arith("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // divu 7 / 0: full latency, HI/LO untouched
      run_arith("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // div 7 / -2 = -3 rem 1
      run_arith("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 10, 32'd1, 32'hFFFF_FFFD);
      // div most-negative / -1
      run_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);
      // divu 100 / 7 = 14 rem 2; back-to-back start right after completion
      run_arith("divu", 3'd3, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);
      run_arith("multu_b2b", 3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 5, 32'd1, 32'd0);

      // mthi then mtlo, D-stage md present: never stalls, never busy
      cyc(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b1, 1'b0, mk("mthi_start", 1'b0, 1'b0, cur_hi, cur_lo));
      cur_hi = 32'h1234_5678;
      cyc(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0, mk("mtlo_start", 1'b0, 1'b0, cur_hi, cur_lo));
      cur_lo = 32'h9ABC_DEF0;
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, mk("mtlo_done", 1'b0, 1'b0, cur_hi, cur_lo));

      // Reserved opcodes are ignored
      cyc(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0, mk("rsvd6", 1'b0, 1'b0, cur_hi, cur_lo));
      cyc(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0, mk("rsvd7", 1'b0, 1'b0, cur_hi, cur_lo));
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, mk("rsvd_after", 1'b0, 1'b0, cur_hi, cur_lo));

      // Reset during the third busy cycle of a divide
      cyc(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0, mk("rstdiv_start", 1'b0, 1'b0, cur_hi, cur_lo));
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, mk("rstdiv_b1", 1'b1, 1'b0, cur_hi, cur_lo));
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, mk("rstdiv_b2", 1'b1, 1'b0, cur_hi, cur_lo));
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, mk("rstdiv_b3", 1'b1, 1'b0, cur_hi, cur_lo));
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      run_arith("mult_after_rst", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && expq.size() > 0; i++)
         @(negedge clk);
      if (expq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", expq.size());
      end
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and sequences a fixed-latency busy window.
- Owns the HI/LO registers and raises a stall request to the hazard logic while any HI/LO-class instruction in D would collide with an active operation.
- Sits beside the ALU in E; mfhi/mflo read the hi/lo outputs.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is valid md-class this cycle
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6,7 reserved
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  output  1  operation in progress
- stall  output  1  freeze PC/F/D and bubble E
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Interface clocking: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, cnt 0, busy 0, hi 0, lo 0, pending results 0. Reset mid-operation aborts it; HI/LO return to 0.
- States:
  - IDLE: waits for start.
  - RUN: counts down.
  - Back to IDLE when done.
- IDLE with start and md_op 0..3:
  - Compute the result combinationally from rs_val/rt_val and latch it into pend_hi/pend_lo.
  - Load cnt with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from the next cycle.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=signed quotient, hi=signed remainder; truncate toward zero, remainder takes the dividend's sign.
  - divu: unsigned.
  - Divide by zero (rt_val==0): still takes DIV_CYCLES busy; HI/LO unchanged at completion.
  - 0x80000000 div 0xFFFFFFFF: lo=0x80000000, hi=0.
- RUN:
  - cnt decrements each cycle.
  - When cnt==1: hi/lo <= pend values at that edge; state IDLE; busy deasserts in the same edge.
  - Total busy = exactly N cycles after the start cycle.
- mthi/mtlo, in IDLE with start:
  - hi (or lo) <= rs_val at the next edge; busy stays 0.
  - Single cycle, no RUN.
- start while busy: ignored; no state change. This is illegal by construction; the bench flags it as an assertion.
- Reserved md_op (6,7) with start: ignored.
- stall = d_is_md && (busy || (start && md_op<=3)). Combinational, no register.
- hi/lo outputs show committed values only; pending results are never visible early.
- Completion cycle and a new start in the same cycle cannot occur, because stall holds D until busy falls. A start on the first IDLE cycle after completion is legal.

Decomposition:
- Shared package (mips_defs): MD_MULT..MD_MTLO opcode constants, state encodings IDLE/RUN, default latencies.
- One natural sub-module, md_arith: pure combinational signed/unsigned mult/div producing a 64-bit {hi,lo} plus a div_by_zero flag. md_ctrl holds only the FSM, counter and HI/LO registers.

Test Plan:
- reset; mult rs=0xFFFFFFFE(-2) rt=3 -> busy high 5 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA after 5th cycle, unchanged before.
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=-7(0xFFFFFFF9) rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7 rt=0 -> 10 busy cycles, HI/LO keep prior values.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 -> hi/lo update next edge each, busy never asserts, stall stays 0.
- div in progress with d_is_md=1 -> stall=1 every busy cycle and in the start cycle; stall=0 once busy falls. With d_is_md=0 -> stall=0 throughout.
- reset asserted at cycle 3 of div -> next edge busy=0, hi=lo=0, state IDLE; a following mult completes normally in 5 cycles.
